// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Round-robin arbitration is enabled with the SRAM_ARB_RR_EN macro.
package sram_arb_pkg;

   localparam int DEF_WAIT_CYCLES = 2;
   localparam int ADDR_W          = 20;
   localparam int DATA_W          = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } arb_state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   // Request fields captured at grant time and held for the whole access
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection for the two SRAM requesters.
// SRAM_ARB_RR_EN builds a last-grant register for round-robin; otherwise port A has fixed priority.
module sram_arb_pick
   import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
   input  logic  clk,
   input  logic  rst_n,
   input  logic  grant_en,
`endif
   input  logic  a_req,
   input  logic  b_req,
   output port_e grant
);

`ifdef SRAM_ARB_RR_EN
   port_e last_q;
   port_e last_d;

   always_comb begin
      if (a_req && b_req) begin
         grant = (last_q == PORT_A) ? PORT_B : PORT_A;
      end else if (a_req) begin
         grant = PORT_A;
      end else begin
         grant = PORT_B;
      end
      last_d = grant_en ? grant : last_q;
   end

   // Reset to B so that A wins the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= PORT_B;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      grant = a_req ? PORT_A : PORT_B;
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and fixed-length access sequencer for the 1Mx16 async SRAM.
// Arbitration mode is selected by SRAM_ARB_RR_EN (round-robin) or its absence (A priority).
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              A_Req,
   input  logic              B_Req,
   input  logic              A_WE,
   input  logic              B_WE,
   input  logic [ADDR_W-1:0] A_Addr,
   input  logic [ADDR_W-1:0] B_Addr,
   input  logic [DATA_W-1:0] A_WData,
   input  logic [DATA_W-1:0] B_WData,
   output logic [DATA_W-1:0] A_RData,
   output logic [DATA_W-1:0] B_RData,
   output logic              A_Ack,
   output logic              B_Ack,
   output logic [ADDR_W-1:0] ADDR,
   output logic              CE,
   output logic              UB,
   output logic              LB,
   output logic              OE,
   output logic              WE,
   output logic [DATA_W-1:0] Mem_Data_Out,
   output logic              Mem_Drive,
   input  logic [DATA_W-1:0] Mem_Data_In
);

   localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   port_e             port_q, port_d;
   req_t              lat_q, lat_d;
   logic              ce_q, ce_d;
   logic              oe_q, oe_d;
   logic              wen_q, wen_d;
   logic              drive_q, drive_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

   logic              any_req;
   port_e             grant;

   assign any_req = A_Req | B_Req;

`ifdef SRAM_ARB_RR_EN
   logic grant_en;
   assign grant_en = (state_q == IDLE) && any_req;
`endif

   sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
      .clk      (Clk),
      .rst_n    (Reset),
      .grant_en (grant_en),
`endif
      .a_req    (A_Req),
      .b_req    (B_Req),
      .grant    (grant)
   );

   // Strobes are decoded from the state being entered so they are registered outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      port_d    = port_q;
      lat_d     = lat_q;
      ce_d      = ce_q;
      oe_d      = oe_q;
      wen_d     = wen_q;
      drive_d   = drive_q;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;

      unique case (state_q)
         IDLE: begin
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            wen_d   = 1'b1;
            drive_d = 1'b0;
            if (any_req) begin
               port_d = grant;
               if (grant == PORT_A) begin
                  lat_d.we    = A_WE;
                  lat_d.addr  = A_Addr;
                  lat_d.wdata = A_WData;
               end else begin
                  lat_d.we    = B_WE;
                  lat_d.addr  = B_Addr;
                  lat_d.wdata = B_WData;
               end
               state_d = SETUP;
               ce_d    = 1'b0;
               drive_d = lat_d.we;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
            oe_d    = lat_q.we;
            wen_d   = ~lat_q.we;
            drive_d = lat_q.we;
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               ce_d    = 1'b1;
               oe_d    = 1'b1;
               wen_d   = 1'b1;
               drive_d = lat_q.we;
               if (port_q == PORT_A) begin
                  a_ack_d = 1'b1;
                  if (!lat_q.we) a_rdata_d = Mem_Data_In;
               end else begin
                  b_ack_d = 1'b1;
                  if (!lat_q.we) b_rdata_d = Mem_Data_In;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ce_d    = 1'b1;
            oe_d    = 1'b1;
            wen_d   = 1'b1;
            drive_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         port_q    <= PORT_A;
         lat_q     <= '0;
         ce_q      <= 1'b1;
         oe_q      <= 1'b1;
         wen_q     <= 1'b1;
         drive_q   <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         port_q    <= port_d;
         lat_q     <= lat_d;
         ce_q      <= ce_d;
         oe_q      <= oe_d;
         wen_q     <= wen_d;
         drive_q   <= drive_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   // Only full-word accesses, so the byte lanes follow chip enable
   assign ADDR         = lat_q.addr;
   assign Mem_Data_Out = lat_q.wdata;
   assign CE           = ce_q;
   assign UB           = ce_q;
   assign LB           = ce_q;
   assign OE           = oe_q;
   assign WE           = wen_q;
   assign Mem_Drive    = drive_q;
   assign A_Ack        = a_ack_q;
   assign B_Ack        = b_ack_q;
   assign A_RData      = a_rdata_q;
   assign B_RData      = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural 1Mx16 SRAM model.
// Expectations for the tie test follow SRAM_ARB_RR_EN.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        Reset;
   logic        A_Req, B_Req, A_WE, B_WE;
   logic [19:0] A_Addr, B_Addr;
   logic [15:0] A_WData, B_WData;
   logic [15:0] A_RData, B_RData;
   logic        A_Ack, B_Ack;
   logic [19:0] ADDR;
   logic        CE, UB, LB, OE, WE;
   logic [15:0] Mem_Data_Out, Mem_Data_In;
   logic        Mem_Drive;

   logic        a1_req;
   logic [19:0] a1_addr;
   logic [15:0] a1_rdata, b1_rdata, mdo1, mdi1;
   logic        a1_ack, b1_ack;
   logic [19:0] addr1;
   logic        ce1, ub1, lb1, oe1, we1, drive1;

   logic [15:0] mem [0:1048575];
   logic        pl_en;
   logic [19:0] pl_addr;
   logic [15:0] pl_data;

   int n_checks = 0;
   int n_fail   = 0;

   int a_ack_cnt, b_ack_cnt, a_ack_first, b_ack_first;
   int oe_low_cnt, we_low_cnt, drive_cnt, drive_first, drive_last, overlap_cnt;
   int order_n;
   int order [0:7];

   always #5 clk = ~clk;

   sram_arbiter #(.WAIT_CYCLES(2)) dut (
      .Clk(clk), .Reset(Reset),
      .A_Req(A_Req), .B_Req(B_Req), .A_WE(A_WE), .B_WE(B_WE),
      .A_Addr(A_Addr), .B_Addr(B_Addr), .A_WData(A_WData), .B_WData(B_WData),
      .A_RData(A_RData), .B_RData(B_RData), .A_Ack(A_Ack), .B_Ack(B_Ack),
      .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
      .Mem_Data_Out(Mem_Data_Out), .Mem_Drive(Mem_Drive), .Mem_Data_In(Mem_Data_In)
   );

   sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
      .Clk(clk), .Reset(Reset),
      .A_Req(a1_req), .B_Req(1'b0), .A_WE(1'b0), .B_WE(1'b0),
      .A_Addr(a1_addr), .B_Addr(20'h0), .A_WData(16'h0), .B_WData(16'h0),
      .A_RData(a1_rdata), .B_RData(b1_rdata), .A_Ack(a1_ack), .B_Ack(b1_ack),
      .ADDR(addr1), .CE(ce1), .UB(ub1), .LB(lb1), .OE(oe1), .WE(we1),
      .Mem_Data_Out(mdo1), .Mem_Drive(drive1), .Mem_Data_In(mdi1)
   );

   // SRAM model: combinational read while selected, write on clock while WE is low
   assign Mem_Data_In = (!CE && !OE) ? mem[ADDR] : 16'h0000;
   assign mdi1        = (!ce1 && !oe1) ? (addr1[15:0] ^ 16'hC3C3) : 16'h0000;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (!CE && !WE && Mem_Drive) mem[ADDR] <= Mem_Data_Out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [19:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Observe n cycles after the request edge; optionally drop req on its ack
   task automatic observe(input int ncyc, input bit hold);
      a_ack_cnt = 0; b_ack_cnt = 0; a_ack_first = 0; b_ack_first = 0;
      oe_low_cnt = 0; we_low_cnt = 0; drive_cnt = 0; drive_first = 0;
      drive_last = 0; overlap_cnt = 0; order_n = 0;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         if (!OE) oe_low_cnt++;
         if (!WE) we_low_cnt++;
         if (!OE && Mem_Drive) overlap_cnt++;
         if (Mem_Drive) begin
            drive_cnt++;
            if (drive_first == 0) drive_first = i;
            drive_last = i;
         end
         if (A_Ack) begin
            a_ack_cnt++;
            if (a_ack_first == 0) a_ack_first = i;
            if (order_n < 8) order[order_n] = 0;
            order_n++;
            if (!hold) A_Req = 1'b0;
         end
         if (B_Ack) begin
            b_ack_cnt++;
            if (b_ack_first == 0) b_ack_first = i;
            if (order_n < 8) order[order_n] = 1;
            order_n++;
            if (!hold) B_Req = 1'b0;
         end
      end
   endtask

   initial begin
      Reset = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      A_Req = 0; B_Req = 0; A_WE = 0; B_WE = 0;
      A_Addr = '0; B_Addr = '0; A_WData = '0; B_WData = '0;
      a1_req = 0; a1_addr = '0;
      @(negedge clk);
      preload(20'h00010, 16'h1234);
      preload(20'h00020, 16'h1111);
      preload(20'h00030, 16'h5678);
      @(negedge clk);

      // Reset values
      check("rst_strobes", {27'b0, CE, UB, LB, OE, WE}, 32'h1F);
      check("rst_drive", {31'b0, Mem_Drive}, 32'h0);
      check("rst_addr", {12'b0, ADDR}, 32'h0);
      check("rst_mdo", {16'b0, Mem_Data_Out}, 32'h0);
      check("rst_acks", {30'b0, A_Ack, B_Ack}, 32'h0);
      check("rst_rdata", {A_RData, B_RData}, 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      Reset = 1'b1;
      @(negedge clk);

      // Single read by A, W=2
      A_Req = 1; A_WE = 0; A_Addr = 20'h00010;
      observe(7, 1'b0);
      check("rd_ack_cycle", a_ack_first, 4);
      check("rd_ack_count", a_ack_cnt, 1);
      check("rd_data", {16'b0, A_RData}, 32'h1234);
      check("rd_oe_low", oe_low_cnt, 2);
      check("rd_drive", drive_cnt, 0);
      check("rd_no_b_ack", b_ack_cnt, 0);

      // Single write by B
      B_Req = 1; B_WE = 1; B_Addr = 20'h0FFFF; B_WData = 16'hBEEF;
      observe(7, 1'b0);
      check("wr_we_low", we_low_cnt, 2);
      check("wr_drive_first", drive_first, 1);
      check("wr_drive_last", drive_last, 4);
      check("wr_drive_cnt", drive_cnt, 4);
      check("wr_ack_count", b_ack_cnt, 1);
      check("wr_ack_cycle", b_ack_first, 4);
      check("wr_mem", {16'b0, mem[20'h0FFFF]}, 32'hBEEF);
      check("wr_oe_drive", overlap_cnt, 0);
      B_WE = 0;

      // Both request continuously
      A_Req = 1; A_Addr = 20'h00010; B_Req = 1; B_Addr = 20'h00030;
      observe(20, 1'b1);
      A_Req = 0; B_Req = 0;
      check("tie_ack_total", order_n, 4);
`ifdef SRAM_ARB_RR_EN
      check("tie_g0", order[0], 0);
      check("tie_g1", order[1], 1);
      check("tie_g2", order[2], 0);
      check("tie_g3", order[3], 1);
      check("tie_b_data", {16'b0, B_RData}, 32'h5678);
`else
      check("tie_a_cnt", a_ack_cnt, 4);
      check("tie_b_cnt", b_ack_cnt, 0);
`endif
      check("tie_oe_drive", overlap_cnt, 0);
      @(negedge clk);
      @(negedge clk);

      // Reset in the first ACCESS cycle of an A read
      A_Req = 1; A_Addr = 20'h00010;
      @(negedge clk);
      @(negedge clk);
      check("rsta_in_access", 32'(dut.state_q), 32'(ACCESS));
      check("rsta_oe_low", {31'b0, OE}, 32'h0);
      Reset = 0; A_Req = 0;
      @(negedge clk);
      check("rsta_strobes", {27'b0, CE, UB, LB, OE, WE}, 32'h1F);
      check("rsta_state", 32'(dut.state_q), 32'(IDLE));
      check("rsta_ack", {31'b0, A_Ack}, 32'h0);
      check("rsta_rdata", {16'b0, A_RData}, 32'h0);
      Reset = 1;
      observe(5, 1'b0);
      check("rsta_no_late_ack", a_ack_cnt, 0);

      // Withdrawn B request during A access
      A_Req = 1; A_Addr = 20'h00030;
      @(negedge clk);
      B_Req = 1; B_WE = 1; B_Addr = 20'h00020; B_WData = 16'hDEAD;
      @(negedge clk);
      B_Req = 0; B_WE = 0;
      observe(6, 1'b0);
      check("wd_a_ack_cycle", a_ack_first, 2);
      check("wd_a_ack_cnt", a_ack_cnt, 1);
      check("wd_a_data", {16'b0, A_RData}, 32'h5678);
      check("wd_no_b_ack", b_ack_cnt, 0);
      check("wd_no_write", we_low_cnt, 0);
      check("wd_mem_intact", {16'b0, mem[20'h00020]}, 32'h1111);

      // Max address, W=1
      a1_req = 1; a1_addr = 20'hFFFFF;
      @(negedge clk);
      check("max_setup_addr", {12'b0, addr1}, 32'hFFFFF);
      check("max_setup_ce_oe", {30'b0, ce1, oe1}, 32'h1);
      @(negedge clk);
      check("max_access_addr", {12'b0, addr1}, 32'hFFFFF);
      check("max_access_oe", {31'b0, oe1}, 32'h0);
      check("max_access_noack", {31'b0, a1_ack}, 32'h0);
      @(negedge clk);
      check("max_ack", {31'b0, a1_ack}, 32'h1);
      check("max_rdata", {16'b0, a1_rdata}, 32'h3C3C);
      a1_req = 0;
      @(negedge clk);
      check("max_ack_pulse", {31'b0, a1_ack}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
